// File: rtl/keyboard_responder.sv
// Keyboard/mouse responder: receives serial host frames (queries and the host
// reset frame) and answers queries with a 20-bit word from the keyboard or
// mouse holding register after a fixed turnaround.
module keyboard_responder #(
   parameter int unsigned BIT_PERIOD = 265,
   parameter int unsigned TURNAROUND = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        from_host,
   output logic        to_host,
   input  logic        kb_valid,
   input  logic [15:0] kb_data,
   output logic        kb_ready,
   input  logic        ms_valid,
   input  logic [15:0] ms_data,
   output logic        ms_ready,
   output logic        initialized
);

   localparam int unsigned HALF_PERIOD = BIT_PERIOD / 2;
   localparam int unsigned TURN_CLKS   = BIT_PERIOD * TURNAROUND;
   localparam int unsigned CNT_MAX     = (TURN_CLKS > BIT_PERIOD) ? TURN_CLKS : BIT_PERIOD;
   localparam int unsigned CNT_W       = $clog2(CNT_MAX + 1);
   localparam int unsigned BIT_W       = 5;
   localparam int unsigned HDR_BITS    = 8;
   localparam int unsigned RST_BITS    = 21;
   localparam int unsigned TX_BITS     = 20;
   localparam int unsigned WORD_W      = 20;
   localparam int unsigned SHIFT_W     = 12;

   localparam logic [7:0]        HDR_KB    = 8'b00001000;
   localparam logic [7:0]        HDR_MS    = 8'b10001000;
   localparam logic [7:0]        HDR_RST   = 8'b11110111;
   localparam logic [12:0]       RST_TAIL  = 13'b1110000000000;
   localparam logic [WORD_W-1:0] IDLE_WORD = 20'h80300;

   typedef enum logic [2:0] {
      IDLE,
      RX_START,
      RX_BITS,
      RX_WAIT_HIGH,
      TURN,
      TX
   } state_t;

   typedef enum logic [1:0] {
      Q_NONE,
      Q_KB,
      Q_MS
   } query_t;

   state_t              state_q, state_d;
   logic [1:0]          sync_q;
   logic                line_prev_q;
   logic                rx_line;
   logic                line_fall;

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [SHIFT_W-1:0]  shreg_q, shreg_d;
   logic [SHIFT_W:0]    rx_shift;
   query_t              query_q, query_d;
   logic [WORD_W-1:0]   tx_word_q, tx_word_d;
   logic                tx_consume_q, tx_consume_d;
   logic                to_host_d;
   logic                init_d;

   logic                kb_full_q, kb_full_d;
   logic [15:0]         kb_hold_q, kb_hold_d;
   logic                ms_full_q, ms_full_d;
   logic [15:0]         ms_hold_q, ms_hold_d;

   logic                half_done;
   logic                period_done;
   logic                turn_done;
   logic                hdr_last;
   logic                rst_last;
   logic                tx_last;
   logic                flush;
   logic                consume;

   assign rx_line     = sync_q[1];
   assign line_fall   = line_prev_q & ~rx_line;
   assign rx_shift    = {shreg_q, rx_line};
   assign half_done   = (cnt_q == CNT_W'(HALF_PERIOD - 1));
   assign period_done = (cnt_q == CNT_W'(BIT_PERIOD - 1));
   assign turn_done   = (TURN_CLKS == 0) || (cnt_q == CNT_W'(TURN_CLKS - 1));
   assign hdr_last    = (bit_cnt_q == BIT_W'(HDR_BITS - 1));
   assign rst_last    = (bit_cnt_q == BIT_W'(RST_BITS - 1));
   assign tx_last     = (bit_cnt_q == BIT_W'(TX_BITS));

   assign kb_ready = ~kb_full_q;
   assign ms_ready = ~ms_full_q;

   // Two-flop synchronizer for the asynchronous host line plus edge history
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q      <= 2'b11;
         line_prev_q <= 1'b1;
      end else begin
         sync_q      <= {sync_q[0], from_host};
         line_prev_q <= sync_q[1];
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (line_fall) state_d = RX_START;
         end
         RX_START: begin
            if (half_done) state_d = rx_line ? IDLE : RX_BITS;
         end
         RX_BITS: begin
            if (period_done) begin
               if (hdr_last) begin
                  if (rx_shift[7:0] != HDR_RST) state_d = RX_WAIT_HIGH;
               end else if (rst_last) begin
                  state_d = RX_WAIT_HIGH;
               end
            end
         end
         RX_WAIT_HIGH: begin
            if (rx_line) state_d = (query_q != Q_NONE && initialized) ? TURN : IDLE;
         end
         TURN: begin
            if (turn_done) state_d = TX;
         end
         TX: begin
            if (period_done && tx_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath and output next values: counters, receive shifter, transmit word, holding registers
   always_comb begin
      cnt_d        = cnt_q + CNT_W'(1);
      bit_cnt_d    = bit_cnt_q;
      shreg_d      = shreg_q;
      query_d      = query_q;
      tx_word_d    = tx_word_q;
      tx_consume_d = tx_consume_q;
      to_host_d    = to_host;
      init_d       = initialized;
      flush        = 1'b0;
      consume      = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d     = '0;
            to_host_d = 1'b1;
         end
         RX_START: begin
            if (half_done) begin
               cnt_d     = '0;
               bit_cnt_d = '0;
               query_d   = Q_NONE;
            end
         end
         RX_BITS: begin
            if (period_done) begin
               cnt_d     = '0;
               shreg_d   = rx_shift[SHIFT_W-1:0];
               bit_cnt_d = bit_cnt_q + BIT_W'(1);
               if (hdr_last) begin
                  if (rx_shift[7:0] == HDR_KB)      query_d = Q_KB;
                  else if (rx_shift[7:0] == HDR_MS) query_d = Q_MS;
                  else                              query_d = Q_NONE;
               end
               if (rst_last && rx_shift == RST_TAIL) begin
                  init_d = 1'b1;
                  flush  = 1'b1;
               end
            end
         end
         RX_WAIT_HIGH: begin
            cnt_d = '0;
         end
         TURN: begin
            if (turn_done) begin
               cnt_d     = '0;
               bit_cnt_d = '0;
               to_host_d = 1'b0;
               case (query_q)
                  Q_KB: begin
                     tx_word_d    = kb_full_q ? {1'b0, kb_hold_q[15:8], 3'b010, kb_hold_q[7:0]}
                                              : IDLE_WORD;
                     tx_consume_d = kb_full_q;
                  end
                  Q_MS: begin
                     tx_word_d    = ms_full_q ? {1'b0, ms_hold_q[15:8], 3'b010, ms_hold_q[7:0]}
                                              : IDLE_WORD;
                     tx_consume_d = ms_full_q;
                  end
                  default: begin
                     tx_word_d    = IDLE_WORD;
                     tx_consume_d = 1'b0;
                  end
               endcase
            end
         end
         TX: begin
            if (period_done) begin
               cnt_d = '0;
               if (tx_last) begin
                  to_host_d = 1'b1;
                  consume   = tx_consume_q;
               end else begin
                  to_host_d = tx_word_q[0];
                  tx_word_d = tx_word_q >> 1;
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end
         end
         default: begin
            cnt_d     = '0;
            to_host_d = 1'b1;
         end
      endcase

      // Holding registers: flush/consume first, then accept a new event if empty
      kb_full_d = kb_full_q;
      kb_hold_d = kb_hold_q;
      ms_full_d = ms_full_q;
      ms_hold_d = ms_hold_q;
      if (flush || (consume && query_q == Q_KB)) kb_full_d = 1'b0;
      if (flush || (consume && query_q == Q_MS)) ms_full_d = 1'b0;
      if (kb_valid && kb_ready) begin
         kb_full_d = 1'b1;
         kb_hold_d = kb_data;
      end
      if (ms_valid && ms_ready) begin
         ms_full_d = 1'b1;
         ms_hold_d = ms_data;
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q        <= '0;
         bit_cnt_q    <= '0;
         shreg_q      <= '0;
         query_q      <= Q_NONE;
         tx_word_q    <= '0;
         tx_consume_q <= 1'b0;
         to_host      <= 1'b1;
         initialized  <= 1'b0;
         kb_full_q    <= 1'b0;
         kb_hold_q    <= '0;
         ms_full_q    <= 1'b0;
         ms_hold_q    <= '0;
      end else begin
         cnt_q        <= cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shreg_q      <= shreg_d;
         query_q      <= query_d;
         tx_word_q    <= tx_word_d;
         tx_consume_q <= tx_consume_d;
         to_host      <= to_host_d;
         initialized  <= init_d;
         kb_full_q    <= kb_full_d;
         kb_hold_q    <= kb_hold_d;
         ms_full_q    <= ms_full_d;
         ms_hold_q    <= ms_hold_d;
      end
   end

endmodule

// File: doc/keyboard_responder.md
KEYBOARD_RESPONDER -- requirements
Module: keyboard_responder

Interface
REQ-001 SHALL have parameter BIT_PERIOD, default 265; clocks per serial bit (53 us at mon clk).
REQ-002 SHALL have parameter TURNAROUND, default 3; idle bit periods between end of a host query and start of the response.
REQ-003 clk  input  1  mon clock; one clock domain, all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 from_host  input  1  serial line driven by the host keyboard controller; idle high; asynchronous to clk.
REQ-006 to_host  output  1  serial response line to the host; idle high.
REQ-007 kb_valid  input  1  keyboard event offered.
REQ-008 kb_data  input  16  keyboard event: [15:8] high byte, [7:0] low byte.
REQ-009 kb_ready  output  1  keyboard holding register empty; event accepted on the cycle where kb_valid && kb_ready.
REQ-010 ms_valid / ms_data[15:0] / ms_ready  SHALL be the mouse equivalents of REQ-007..009.
REQ-011 initialized  output  1  a valid host reset frame has been received since the last reset.

Function
REQ-012 SHALL pass from_host through a 2-flop synchronizer; all receive logic uses the synchronized value.
REQ-013 SHALL implement states IDLE, RX_START, RX_BITS, RX_WAIT_HIGH, TURN, TX.
REQ-014 IDLE: a synchronized falling edge moves to RX_START; from_host is ignored in TURN and TX.
REQ-015 RX_START: after BIT_PERIOD/2 clocks (132), line still low moves to RX_BITS; line high returns to IDLE (glitch reject).
REQ-016 RX_BITS: SHALL sample every BIT_PERIOD clocks thereafter and shift bits in MSB-first; the first 8 bits form the header.
REQ-017 Header 8'b00001000 is a keyboard query and header 8'b10001000 is a mouse query; either moves to RX_WAIT_HIGH.
REQ-018 Header 8'b11110111 SHALL receive 13 further bits; tail 13'b1110000000000 sets initialized=1 and flushes both holding registers (kb_ready=ms_ready=1); any other tail is ignored.
REQ-019 Any other header is ignored; SHALL go to RX_WAIT_HIGH and then IDLE without responding.
REQ-020 RX_WAIT_HIGH: waits for the line high. For a query with initialized=1, moves to TURN; otherwise moves to IDLE.
REQ-021 TURN: SHALL wait TURNAROUND*BIT_PERIOD clocks, then enter TX.
REQ-022 TX: SHALL drive start bit 0, then 20 data bits D[0] first through D[19], each BIT_PERIOD clocks; then to_host=1 and state IDLE.
REQ-023 Response word D[19:0] SHALL be {1'b0, hi[7:0], 3'b010, lo[7:0]} when the queried holding register is full; otherwise 20'h80300 (ready/idle word).
REQ-024 The response word SHALL be latched on entry to TX; events accepted during TX do not alter the frame in flight.
REQ-025 A full holding register SHALL clear on the clock after the last data bit period ends; ready rises that cycle.
REQ-026 kb_ready = !kb_full and ms_ready = !ms_full, combinational from the registers; valid while full has no effect.
REQ-027 Keyboard and mouse registers are independent; a query for one SHALL never consume or alter the other.
REQ-028 Bit and period counters SHALL be sized to hold BIT_PERIOD*TURNAROUND without wrap.

Reset
REQ-029 On reset: to_host=1, state IDLE, initialized=0, kb_ready=1, ms_ready=1, all counters 0; effective the next clock, including mid-frame.

Verification
REQ-030 Reset, then keyboard query 00001000 -> no falling edge on to_host for 40 bit periods; initialized=0.
REQ-031 Reset frame 111101111110000000000, then keyboard query -> initialized=1; 3 periods after query end, to_host sends 0 then bits of 20'h80300, LSB first.
REQ-032 kb_data=16'hA55A with valid -> kb_ready=0 next cycle; keyboard query -> word 20'h52A5A sent; kb_ready=1 the cycle after the D19 period ends.
REQ-033 kb register full, mouse query 10001000 -> 20'h80300 sent; kb_ready stays 0; next keyboard query sends 20'h52A5A.
REQ-034 10-clock low glitch on from_host -> stays IDLE. Header 8'h55 -> no response. Reset header with a bad tail -> initialized unchanged.
REQ-035 reset asserted during TX bit 7 -> to_host=1 on the next clock, kb_ready=1, and no further transmission.
